// File: rtl/beam_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : beam_sort_ctrl
// Purpose  : Beam-sort window controller for PUSCH dimension reduction.
//            Accumulates per-beam power over NSYM symbols, issues one sort
//            request per window and holds the returned top-16 beam index
//            list until the next window completes.
// Revision : 1.0  initial release
// ============================================================================
module beam_sort_ctrl #(
  parameter int IW   = 32,
  parameter int COL  = 64,
  parameter int NSYM = 14,
  parameter int TMO  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_slot_start,
  input  logic                     i_pwr_valid,
  input  logic [COL-1:0][IW-1:0]   i_pwr,
  output logic [COL-1:0][IW-1:0]   o_sort_data,
  output logic                     o_sort_valid,
  input  logic                     i_sort_tvalid,
  input  logic [15:0][7:0]         i_sort_index,
  output logic [15:0][7:0]         o_beam_index,
  output logic                     o_index_valid,
  output logic                     o_index_update,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic                     o_drop
);

  localparam int CW = $clog2(NSYM + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [CW-1:0] NSYM_C = CW'(NSYM);
  localparam logic [TW-1:0] TMO_C  = TW'(TMO);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    CAPT  = 3'd4
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [COL-1:0][IW-1:0]   acc;
  logic [COL-1:0][IW-1:0]   acc_nxt;
  logic [COL-1:0][IW-1:0]   acc_sum;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_nxt;
  logic [TW-1:0]            tmr;
  logic [TW-1:0]            tmr_nxt;
  logic                     pend;
  logic                     pend_nxt;
  logic                     exit_pend;
  logic                     capt;
  logic                     drop_nxt;
  logic                     tmo_nxt;

  // Per-beam saturating add of the incoming symbol onto the accumulator.
  for (genvar b = 0; b < COL; b++) begin : g_sat
    logic [IW:0] sum;
    assign sum        = {1'b0, acc[b]} + {1'b0, i_pwr[b]};
    assign acc_sum[b] = sum[IW] ? {IW{1'b1}} : sum[IW-1:0];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic for the window/sort handshake.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    tmr_nxt   = tmr;
    pend_nxt  = pend;
    drop_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    capt      = 1'b0;
    // A start arriving in the exit cycle itself still counts as pending.
    exit_pend = pend | i_slot_start;
    unique case (state)
      IDLE, ACCUM: begin
        if (i_slot_start) begin
          // Open (or restart) a window; a coincident symbol is its first.
          state_nxt = ACCUM;
          if (i_pwr_valid) begin
            acc_nxt = i_pwr;
            cnt_nxt = CW'(1);
            if (cnt_nxt == NSYM_C) state_nxt = ISSUE;
          end else begin
            acc_nxt = '0;
            cnt_nxt = '0;
          end
        end else if (state == ACCUM) begin
          if (i_pwr_valid) begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt + CW'(1);
            if (cnt_nxt == NSYM_C) state_nxt = ISSUE;
          end
        end else begin
          drop_nxt = i_pwr_valid;
        end
      end
      ISSUE: begin
        pend_nxt  = exit_pend;
        drop_nxt  = i_pwr_valid;
        tmr_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        pend_nxt = exit_pend;
        drop_nxt = i_pwr_valid;
        if (i_sort_tvalid) begin
          state_nxt = CAPT;
        end else if (tmr == TMO_C) begin
          tmo_nxt   = 1'b1;
          pend_nxt  = 1'b0;
          state_nxt = exit_pend ? ACCUM : IDLE;
          if (exit_pend) begin
            acc_nxt = '0;
            cnt_nxt = '0;
          end
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      CAPT: begin
        capt      = 1'b1;
        drop_nxt  = i_pwr_valid;
        pend_nxt  = 1'b0;
        state_nxt = exit_pend ? ACCUM : IDLE;
        if (exit_pend) begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc            <= '0;
      cnt            <= '0;
      tmr            <= '0;
      pend           <= 1'b0;
      o_sort_data    <= '0;
      o_sort_valid   <= 1'b0;
      o_beam_index   <= '0;
      o_index_valid  <= 1'b0;
      o_index_update <= 1'b0;
      o_busy         <= 1'b0;
      o_timeout      <= 1'b0;
      o_drop         <= 1'b0;
    end else begin
      acc            <= acc_nxt;
      cnt            <= cnt_nxt;
      tmr            <= tmr_nxt;
      pend           <= pend_nxt;
      o_sort_valid   <= (state_nxt == ISSUE);
      if (state_nxt == ISSUE) o_sort_data <= acc_nxt;
      // The sorter's index register settles one cycle after its valid.
      if (capt) begin
        o_beam_index  <= i_sort_index;
        o_index_valid <= 1'b1;
      end
      o_index_update <= capt;
      o_busy         <= (state_nxt != IDLE);
      o_timeout      <= tmo_nxt;
      o_drop         <= drop_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beam_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_beam_sort_ctrl
// Purpose  : Self-checking bench for beam_sort_ctrl (scoreboard of sort
//            requests and captured index lists plus per-scenario checks).
// Revision : 1.0  initial release
// ============================================================================
module tb_beam_sort_ctrl;
  localparam int IW   = 32;
  localparam int COL  = 64;
  localparam int NSYM = 4;
  localparam int TMO  = 16;

  typedef logic [COL-1:0][IW-1:0] data_t;
  typedef logic [15:0][7:0]       idx_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  slot_start, pwr_valid, sort_tvalid;
  data_t pwr, sort_data;
  idx_t  sort_index, beam_index;
  logic  sort_valid, index_valid, index_update, busy, timeout, drop;

  int vectors = 0;
  int errors  = 0;
  data_t exp_data_q[$];
  idx_t  exp_idx_q[$];

  always #5 clk = ~clk;

  beam_sort_ctrl #(.IW(IW), .COL(COL), .NSYM(NSYM), .TMO(TMO)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_slot_start   (slot_start),
    .i_pwr_valid    (pwr_valid),
    .i_pwr          (pwr),
    .o_sort_data    (sort_data),
    .o_sort_valid   (sort_valid),
    .i_sort_tvalid  (sort_tvalid),
    .i_sort_index   (sort_index),
    .o_beam_index   (beam_index),
    .o_index_valid  (index_valid),
    .o_index_update (index_update),
    .o_busy         (busy),
    .o_timeout      (timeout),
    .o_drop         (drop)
  );

  // Scoreboard: sort requests and index updates are checked as they appear.
  always @(negedge clk) begin
    if (sort_valid) begin
      vectors++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL sort_data: unexpected sort request, beam0=%h", sort_data[0]);
      end else begin
        data_t e;
        e = exp_data_q.pop_front();
        if (sort_data !== e) begin
          errors++;
          for (int b = 0; b < COL; b++) begin
            if (sort_data[b] !== e[b]) begin
              $display("FAIL sort_data: beam %0d got %h expected %h", b, sort_data[b], e[b]);
              break;
            end
          end
        end
      end
    end
    if (index_update) begin
      vectors++;
      if (exp_idx_q.size() == 0) begin
        errors++;
        $display("FAIL beam_index: unexpected update, got %h", beam_index);
      end else begin
        idx_t ei;
        ei = exp_idx_q.pop_front();
        if (beam_index !== ei) begin
          errors++;
          $display("FAIL beam_index: got %h expected %h", beam_index, ei);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic data_t const_data(input logic [IW-1:0] v);
    data_t d;
    for (int b = 0; b < COL; b++) d[b] = v;
    return d;
  endfunction

  function automatic data_t ramp_data(input int mult);
    data_t d;
    for (int b = 0; b < COL; b++) d[b] = IW'(mult * (b + 1));
    return d;
  endfunction

  function automatic idx_t rev_idx(input int base);
    idx_t x;
    for (int j = 0; j < 16; j++) x[j] = 8'(base - j);
    return x;
  endfunction

  // Present one power symbol (optionally with slot start) for one edge.
  task automatic feed(input data_t p, input logic start);
    pwr        = p;
    pwr_valid  = 1'b1;
    slot_start = start;
    tick();
    pwr_valid  = 1'b0;
    slot_start = 1'b0;
  endtask

  // Return a sorter result: garbage index on the valid cycle, real one after.
  task automatic give_result(input idx_t idx);
    exp_idx_q.push_back(idx);
    sort_tvalid = 1'b1;
    sort_index  = ~idx;
    tick();
    sort_tvalid = 1'b0;
    sort_index  = idx;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    slot_start = 1'b0; pwr_valid = 1'b0; sort_tvalid = 1'b0;
    pwr = '0; sort_index = '0;
    tick(); tick();
    vectors++;
    if ({sort_valid, index_valid, index_update, busy, timeout, drop} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {sort_valid, index_valid, index_update, busy, timeout, drop});
    end
    vectors++;
    if (beam_index !== '0 || sort_data[0] !== '0 || sort_data[COL-1] !== '0) begin
      errors++;
      $display("FAIL reset_data: beam_index %h sort_data0 %h expected 0", beam_index, sort_data[0]);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    feed(ramp_data(1), 1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL nominal_busy_rise: got %b expected 1", busy);
    end
    for (int i = 1; i < NSYM; i++) begin
      vectors++;
      if (sort_valid !== 1'b0) begin
        errors++; $display("FAIL nominal_early_sort: symbol %0d got %b expected 0", i, sort_valid);
      end
      if (i == NSYM - 1) exp_data_q.push_back(ramp_data(NSYM));
      feed(ramp_data(1), 1'b0);
    end
    vectors++;
    if (sort_valid !== 1'b1) begin
      errors++; $display("FAIL nominal_sort_latency: got %b expected 1", sort_valid);
    end
    tick();
    vectors++;
    if (sort_valid !== 1'b0) begin
      errors++; $display("FAIL nominal_sort_pulse: got %b expected 0", sort_valid);
    end
    tick(); tick();
    vectors++;
    if (index_valid !== 1'b0 || index_update !== 1'b0) begin
      errors++; $display("FAIL nominal_pre_capture: valid %b update %b expected 0 0", index_valid, index_update);
    end
    give_result(rev_idx(63));
    vectors++;
    if (index_update !== 1'b1 || index_valid !== 1'b1) begin
      errors++; $display("FAIL nominal_capture: update %b valid %b expected 1 1", index_update, index_valid);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL nominal_busy_fall: got %b expected 0", busy);
    end
    tick();
    vectors++;
    if (index_update !== 1'b0) begin
      errors++; $display("FAIL nominal_update_pulse: got %b expected 0", index_update);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NSYM; i++) begin
      if (i == NSYM - 1) exp_data_q.push_back(const_data(32'hFFFF_FFFF));
      feed(const_data(32'hC000_0000), (i == 0));
    end
    vectors++;
    if (sort_valid !== 1'b1) begin
      errors++; $display("FAIL sat_sort_valid: got %b expected 1", sort_valid);
    end
    tick();
    give_result(rev_idx(20));
    tick();
  endtask

  task automatic test_timeout();
    int n;
    for (int i = 0; i < NSYM; i++) begin
      if (i == NSYM - 1) exp_data_q.push_back(ramp_data(NSYM));
      feed(ramp_data(1), (i == 0));
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout && n < 4 * TMO);
    vectors++;
    if (n !== TMO + 2) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO + 2);
    end
    vectors++;
    if (busy !== 1'b0 || beam_index !== rev_idx(20) || index_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_hold: busy %b index %h valid %b expected 0 %h 1",
                         busy, beam_index, index_valid, rev_idx(20));
    end
    tick();
    vectors++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got %b expected 0", timeout);
    end
    sort_tvalid = 1'b1;
    sort_index  = rev_idx(5);
    tick();
    sort_tvalid = 1'b0;
    tick(); tick();
    vectors++;
    if (beam_index !== rev_idx(20) || busy !== 1'b0) begin
      errors++; $display("FAIL late_tvalid: index %h busy %b expected %h 0", beam_index, busy, rev_idx(20));
    end
  endtask

  task automatic test_restart();
    feed(const_data(5), 1'b1);
    feed(const_data(5), 1'b0);
    feed(const_data(7), 1'b1);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sort_valid !== 1'b0) begin
        errors++; $display("FAIL restart_early_sort: step %0d got %b expected 0", i, sort_valid);
      end
      if (i == 2) exp_data_q.push_back(const_data(7 + 3 * 5));
      feed(const_data(5), 1'b0);
    end
    vectors++;
    if (sort_valid !== 1'b1) begin
      errors++; $display("FAIL restart_sort: got %b expected 1", sort_valid);
    end
    tick();
    give_result(rev_idx(50));
    tick();
  endtask

  task automatic test_pending_drop();
    for (int i = 0; i < NSYM; i++) begin
      if (i == NSYM - 1) exp_data_q.push_back(const_data(2 * NSYM));
      feed(const_data(2), (i == 0));
    end
    tick();
    slot_start = 1'b1; tick();
    tick();
    slot_start = 1'b0;
    feed(const_data(9), 1'b0);
    vectors++;
    if (drop !== 1'b1) begin
      errors++; $display("FAIL wait_drop: got %b expected 1", drop);
    end
    tick();
    vectors++;
    if (drop !== 1'b0) begin
      errors++; $display("FAIL wait_drop_pulse: got %b expected 0", drop);
    end
    give_result(rev_idx(40));
    vectors++;
    if (busy !== 1'b1 || index_update !== 1'b1) begin
      errors++; $display("FAIL pending_reopen: busy %b update %b expected 1 1", busy, index_update);
    end
    for (int i = 0; i < NSYM; i++) begin
      if (i == NSYM - 1) exp_data_q.push_back(const_data(3 * NSYM));
      feed(const_data(3), 1'b0);
    end
    vectors++;
    if (sort_valid !== 1'b1) begin
      errors++; $display("FAIL pending_sort: got %b expected 1", sort_valid);
    end
    tick();
    give_result(rev_idx(30));
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL pending_merge: busy got %b expected 0", busy);
    end
    tick();
  endtask

  task automatic test_idle_drop();
    feed(const_data(1), 1'b0);
    vectors++;
    if (drop !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_drop: drop %b busy %b expected 1 0", drop, busy);
    end
    tick();
    vectors++;
    if (drop !== 1'b0) begin
      errors++; $display("FAIL idle_drop_pulse: got %b expected 0", drop);
    end
  endtask

  task automatic test_reset_wait();
    for (int i = 0; i < NSYM; i++) begin
      if (i == NSYM - 1) exp_data_q.push_back(ramp_data(2 * NSYM));
      feed(ramp_data(2), (i == 0));
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({sort_valid, index_valid, index_update, busy, timeout, drop} !== 6'b0
        || beam_index !== '0 || sort_data !== '0) begin
      errors++;
      $display("FAIL reset_wait_outputs: flags %b index %h sort0 %h expected all 0",
               {sort_valid, index_valid, index_update, busy, timeout, drop}, beam_index, sort_data[0]);
    end
    sort_tvalid = 1'b1;
    sort_index  = rev_idx(7);
    tick();
    sort_tvalid = 1'b0;
    tick(); tick();
    vectors++;
    if (index_valid !== 1'b0 || beam_index !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_wait_tvalid: valid %b index %h busy %b expected 0 0 0",
                         index_valid, beam_index, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_timeout();
    test_restart();
    test_pending_drop();
    test_idle_drop();
    test_reset_wait();
    tick();
    vectors++;
    if (exp_data_q.size() !== 0 || exp_idx_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d sort and %0d index entries left, expected 0",
               exp_data_q.size(), exp_idx_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beam_sort_ctrl.md
# beam_sort_ctrl

Window controller for the beam sorter in the PUSCH dimension-reduction chain. It accumulates per-beam power over a fixed number of symbols in each slot and issues one sort request per window. It then waits for the sorter's result and captures the top-16 beam index list. The list is held stable for the dimension-reduction stage until the next window completes.

## Interface
- IW, 32: width of per-beam power and accumulator words
- COL, 64: number of beams
- NSYM, 14: symbols accumulated per window (≥1)
- TMO, 16: max cycles in WAIT before timeout (≥1)

- i_clk  in  1  clock; single clock domain
- i_reset  in  1  reset; synchronous, active-high
- i_slot_start  in  1  pulse; opens a new accumulation window
- i_pwr_valid  in  1  one symbol of per-beam power present
- i_pwr  in  [COL-1:0][IW-1:0]  per-beam power, unsigned
- o_sort_data  out  [COL-1:0][IW-1:0]  accumulated power to sorter
- o_sort_valid  out  1  one-cycle sort request
- i_sort_tvalid  in  1  sorter result valid
- i_sort_index  in  [15:0][7:0]  sorter top-16 beam indices
- o_beam_index  out  [15:0][7:0]  held top-16 beam indices
- o_index_valid  out  1  sticky; at least one index list captured since reset
- o_index_update  out  1  one-cycle pulse; o_beam_index changed this cycle
- o_busy  out  1  state != IDLE
- o_timeout  out  1  one-cycle pulse; sort result missing
- o_drop  out  1  one-cycle pulse; i_pwr_valid not accepted

## Operation
- States: IDLE, ACCUM, ISSUE, WAIT, CAPT. All outputs are registered.
- Reset:
  - State goes to IDLE.
  - Accumulators, symbol count, timer and pending flag clear to 0.
  - All outputs are 0, including o_beam_index and o_sort_data.
- IDLE:
  - On i_slot_start, clear accumulators and count, then go to ACCUM.
  - If i_pwr_valid is high in the same cycle, that symbol is the first of the window: acc = i_pwr, count = 1.
  - i_pwr_valid without i_slot_start pulses o_drop.
- ACCUM:
  - Each i_pwr_valid does acc[b] += i_pwr[b] for every beam b.
  - The add saturates at 2^IW-1; there is no wrap.
  - Each i_pwr_valid increments count.
  - On the NSYM-th accepted symbol, go to ISSUE.
- i_slot_start in ACCUM restarts the window: accumulators and count clear.
  - If i_pwr_valid is also high, acc = i_pwr and count = 1.
  - Restart takes priority over completion.
- ISSUE:
  - o_sort_valid = 1 for exactly one cycle.
  - o_sort_data = acc; it stays stable through WAIT and CAPT.
  - Clear the timer and go to WAIT.
- WAIT:
  - If i_sort_tvalid is high, go to CAPT.
  - Otherwise increment the timer.
  - When the timer reaches TMO, pulse o_timeout and exit. o_beam_index and o_index_valid are unchanged.
- CAPT (one cycle):
  - o_beam_index <= i_sort_index (the sorter's index register settles one cycle after its valid).
  - o_index_valid <= 1 and o_index_update pulses for one cycle.
- Exit from CAPT or timeout:
  - If pending is set, go to ACCUM with accumulators cleared; pending clears.
  - Otherwise go to IDLE.
- i_slot_start in ISSUE, WAIT or CAPT sets pending; repeated pulses merge into one.
- i_pwr_valid in ISSUE, WAIT or CAPT pulses o_drop and is not accumulated.
- i_sort_tvalid outside WAIT is ignored.

## Timing
- Nth i_pwr_valid sampled at edge k: o_sort_valid is high during cycle k+1 (state ISSUE).
- i_sort_tvalid sampled high at edge m while in WAIT:
  - CAPT during cycle m+1.
  - i_sort_index sampled at edge m+1.
  - New o_beam_index and the o_index_update pulse are visible in cycle m+2.
- Timeout:
  - o_timeout is visible TMO+1 cycles after the WAIT entry edge, if no tvalid arrives.
  - The next state is visible in the same cycle.
- o_drop is visible the cycle after the offending i_pwr_valid.
- Minimum window: i_slot_start plus NSYM back-to-back valids gives NSYM+1 cycles to o_sort_valid (first symbol accepted with start).
- o_busy rises the cycle after i_slot_start is sampled in IDLE and falls the cycle after exit to IDLE.

## Test plan
- **Nominal window:** NSYM=4, COL=64, i_pwr[b]=b+1, slot_start with the first of 4 consecutive valids.
  - o_sort_valid for one cycle and o_sort_data[b]=4(b+1).
  - Return tvalid 3 cycles later with index[j]=63-j.
  - Two cycles after tvalid: o_beam_index[j]=63-j, o_index_update=1, o_index_valid=1.
- **Saturation:** all i_pwr=0xC000_0000 for 4 symbols → o_sort_data all 0xFFFF_FFFF.
- **Timeout:** TMO=16 and no tvalid.
  - o_timeout pulses once; o_beam_index keeps its prior value; state IDLE, o_busy=0.
  - A tvalid arriving later causes no update.
- **Restart:** slot_start plus valid after 2 accepted symbols (i_pwr=5, then 7 with restart).
  - acc=7 after restart; o_sort_valid only after 3 further valids.
  - o_sort_data[b]=7+3·5 when later symbols are 5.
- **Pending and drop:**
  - slot_start during WAIT and a pwr_valid during WAIT → o_drop pulses once.
  - After CAPT, state ACCUM with acc=0 and o_busy stays 1.
- **Reset mid-WAIT:** i_reset high for 1 cycle → all outputs 0 and state IDLE. A subsequent tvalid is ignored and o_index_valid stays 0.
